// File: rtl/dm_sba_axi_lite_bridge_pkg.sv
// Shared types and AXI response encodings for the SBA-to-AXI4-Lite bridge.
package dm_sba_axi_lite_bridge_pkg;

  typedef enum logic [2:0] {
    Idle,
    Write,
    WaitB,
    Read,
    WaitR
  } sba_axi_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  // Maps an AXI response to {bad_address, other_error} as seen by the SBA engine.
  function automatic logic [1:0] resp_to_err(input logic [1:0] resp);
    logic [1:0] err;
    err = 2'b00;
    unique case (resp)
      RespOkay:               err = 2'b00;
      RespExOkay, RespSlvErr: err = 2'b01;
      RespDecErr:             err = 2'b10;
      default:                err = 2'b00;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dm_sba_axi_lite_bridge.sv
// Converts the single-outstanding SBA req/gnt/r_valid port into an AXI4-Lite manager.
module dm_sba_axi_lite_bridge
  import dm_sba_axi_lite_bridge_pkg::*;
#(
  parameter int unsigned BusWidth = 32,
  parameter logic [2:0]  AxProt   = 3'b001
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dmactive_i,
  input  logic                    req_i,
  input  logic [BusWidth-1:0]     add_i,
  input  logic                    we_i,
  input  logic [BusWidth-1:0]     wdata_i,
  input  logic [BusWidth/8-1:0]   be_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [BusWidth-1:0]     r_rdata_o,
  output logic                    r_err_o,
  output logic                    r_other_err_o,
  output logic                    aw_valid_o,
  output logic [BusWidth-1:0]     aw_addr_o,
  output logic [2:0]              aw_prot_o,
  input  logic                    aw_ready_i,
  output logic                    w_valid_o,
  output logic [BusWidth-1:0]     w_data_o,
  output logic [BusWidth/8-1:0]   w_strb_o,
  input  logic                    w_ready_i,
  input  logic                    b_valid_i,
  input  logic [1:0]              b_resp_i,
  output logic                    b_ready_o,
  output logic                    ar_valid_o,
  output logic [BusWidth-1:0]     ar_addr_o,
  output logic [2:0]              ar_prot_o,
  input  logic                    ar_ready_i,
  input  logic                    r_valid_i,
  input  logic [BusWidth-1:0]     r_data_i,
  input  logic [1:0]              r_resp_i,
  output logic                    r_ready_o
);

  localparam int unsigned StrbWidth = BusWidth / 8;

  sba_axi_state_e        state_q;
  logic [BusWidth-1:0]   addr_q;
  logic [BusWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]  be_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  aw_done_c;
  logic                  w_done_c;
  logic [1:0]            err_c;

  // Grant is combinational so a request is accepted in the cycle it appears.
  assign gnt_o = (state_q == Idle) & req_i & dmactive_i;

  assign aw_done_c = aw_done_q | (aw_valid_o & aw_ready_i);
  assign w_done_c  = w_done_q  | (w_valid_o  & w_ready_i);
  assign err_c     = resp_to_err((state_q == WaitB) ? b_resp_i : r_resp_i);

  assign aw_addr_o = addr_q;
  assign ar_addr_o = addr_q;
  assign w_data_o  = wdata_q;
  assign w_strb_o  = be_q;
  assign aw_prot_o = AxProt;
  assign ar_prot_o = AxProt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= Idle;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      aw_valid_o    <= 1'b0;
      w_valid_o     <= 1'b0;
      b_ready_o     <= 1'b0;
      ar_valid_o    <= 1'b0;
      r_ready_o     <= 1'b0;
      r_valid_o     <= 1'b0;
      r_err_o       <= 1'b0;
      r_other_err_o <= 1'b0;
      r_rdata_o     <= '0;
    end else begin
      // Response flags are single-cycle pulses.
      r_valid_o     <= 1'b0;
      r_err_o       <= 1'b0;
      r_other_err_o <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (gnt_o) begin
            addr_q  <= add_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            if (we_i) begin
              state_q    <= Write;
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
            end else begin
              state_q    <= Read;
              ar_valid_o <= 1'b1;
            end
          end
        end
        Write: begin
          if (aw_ready_i) aw_valid_o <= 1'b0;
          if (w_ready_i)  w_valid_o  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            state_q   <= WaitB;
            b_ready_o <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_c;
            w_done_q  <= w_done_c;
          end
        end
        WaitB: begin
          if (b_valid_i) begin
            state_q       <= Idle;
            b_ready_o     <= 1'b0;
            r_valid_o     <= 1'b1;
            r_err_o       <= err_c[1];
            r_other_err_o <= err_c[0];
          end
        end
        Read: begin
          if (ar_ready_i) begin
            state_q    <= WaitR;
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
          end
        end
        WaitR: begin
          if (r_valid_i) begin
            state_q       <= Idle;
            r_ready_o     <= 1'b0;
            r_valid_o     <= 1'b1;
            r_err_o       <= err_c[1];
            r_other_err_o <= err_c[0];
            r_rdata_o     <= (r_resp_i == RespOkay) ? r_data_i : '0;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_sba_axi_lite_bridge.sv
// Directed and randomized bench for the SBA-to-AXI4-Lite bridge with a transaction-level model.
module tb_dm_sba_axi_lite_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmactive;
  logic        req;
  logic [31:0] add;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_other_err;
  logic        aw_valid;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_ready;
  logic        w_valid;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic        b_ready;
  logic        ar_valid;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_ready;
  logic        s_r_valid;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        r_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  dm_sba_axi_lite_bridge #(.BusWidth(32), .AxProt(3'b001)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .req_i(req), .add_i(add), .we_i(we), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata),
    .r_err_o(r_err), .r_other_err_o(r_other_err),
    .aw_valid_o(aw_valid), .aw_addr_o(aw_addr), .aw_prot_o(aw_prot), .aw_ready_i(aw_ready),
    .w_valid_o(w_valid), .w_data_o(w_data), .w_strb_o(w_strb), .w_ready_i(w_ready),
    .b_valid_i(b_valid), .b_resp_i(b_resp), .b_ready_o(b_ready),
    .ar_valid_o(ar_valid), .ar_addr_o(ar_addr), .ar_prot_o(ar_prot), .ar_ready_i(ar_ready),
    .r_valid_i(s_r_valid), .r_data_i(s_r_data), .r_resp_i(s_r_resp), .r_ready_o(r_ready)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference meaning of an AXI response for the SBA engine: {bad address, other error}.
  function automatic logic [1:0] exp_flags(input logic [1:0] resp);
    if (resp == 2'b00) return 2'b00;
    if (resp == 2'b11) return 2'b10;
    return 2'b01;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_aw_valid"}, aw_valid, 1'b0);
    chk1({tag, "_w_valid"}, w_valid, 1'b0);
    chk1({tag, "_ar_valid"}, ar_valid, 1'b0);
    chk1({tag, "_b_ready"}, b_ready, 1'b0);
    chk1({tag, "_r_ready"}, r_ready, 1'b0);
    chk1({tag, "_r_valid"}, r_valid, 1'b0);
    chk1({tag, "_r_err"}, r_err, 1'b0);
    chk1({tag, "_r_other_err"}, r_other_err, 1'b0);
  endtask

  // One read: ar_dly/r_dly are slave stall cycles; hold keeps req high so the
  // next read is granted in the pulse cycle; pre means the grant already happened.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, input bit hold, input bit pre,
                         input bit drop_dm);
    logic [1:0] f;
    if (!pre) begin
      @(negedge clk);
      req = 1'b1; we = 1'b0; add = a; be = 4'($urandom); wdata = $urandom;
      #1;
      chk1("rd_gnt", gnt, 1'b1);
    end
    for (int t = 0; t <= ar_dly; t++) begin
      @(negedge clk);
      req = hold; ar_ready = (t == ar_dly);
      if (!hold) add = $urandom;
      #1;
      chk1("rd_ar_valid", ar_valid, 1'b1);
      chkv("rd_ar_addr", ar_addr, a);
      chkv("rd_ar_prot", 32'(ar_prot), 32'd1);
      chk1("rd_gnt_busy", gnt, 1'b0);
      chk1("rd_r_ready_early", r_ready, 1'b0);
      chk1("rd_aw_valid", aw_valid, 1'b0);
      chk1("rd_r_valid_early", r_valid, 1'b0);
    end
    for (int t = 0; t <= r_dly; t++) begin
      @(negedge clk);
      ar_ready = 1'b0;
      if (drop_dm && t == 0) dmactive = 1'b0;
      s_r_valid = (t == r_dly);
      s_r_data  = (t == r_dly) ? d : $urandom;
      s_r_resp  = (t == r_dly) ? resp : 2'($urandom);
      #1;
      chk1("rd_r_ready", r_ready, 1'b1);
      chk1("rd_ar_dropped", ar_valid, 1'b0);
      chk1("rd_gnt_wait", gnt, 1'b0);
      chk1("rd_no_pulse", r_valid, 1'b0);
      chkv("rd_rdata_hold", r_rdata, exp_rdata);
    end
    exp_rdata = (resp == 2'b00) ? d : 32'h0;
    f = exp_flags(resp);
    @(negedge clk);
    s_r_valid = 1'b0;
    #1;
    chk1("rd_pulse", r_valid, 1'b1);
    chkv("rd_rdata", r_rdata, exp_rdata);
    chk1("rd_err", r_err, f[1]);
    chk1("rd_other_err", r_other_err, f[0]);
    chk1("rd_r_ready_off", r_ready, 1'b0);
    chk1("rd_gnt_pulse", gnt, hold & dmactive);
    if (!hold) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      chk1("rd_pulse_end", r_valid, 1'b0);
      chk1("rd_err_end", r_err, 1'b0);
      chk1("rd_other_end", r_other_err, 1'b0);
      chkv("rd_rdata_keep", r_rdata, exp_rdata);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp, input int aw_dly, input int w_dly,
                          input int b_dly);
    logic [1:0] f;
    int last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    @(negedge clk);
    req = 1'b1; we = 1'b1; add = a; wdata = d; be = s;
    #1;
    chk1("wr_gnt", gnt, 1'b1);
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      req = 1'b0; add = $urandom; wdata = $urandom; be = 4'($urandom);
      aw_ready = (t == aw_dly); w_ready = (t == w_dly);
      #1;
      chk1("wr_aw_valid", aw_valid, t <= aw_dly);
      chk1("wr_w_valid", w_valid, t <= w_dly);
      if (t <= aw_dly) chkv("wr_aw_addr", aw_addr, a);
      if (t <= w_dly) begin
        chkv("wr_w_data", w_data, d);
        chkv("wr_w_strb", 32'(w_strb), 32'(s));
      end
      chk1("wr_b_ready_early", b_ready, 1'b0);
      chk1("wr_gnt_busy", gnt, 1'b0);
      chk1("wr_ar_valid", ar_valid, 1'b0);
    end
    for (int t = 0; t <= b_dly; t++) begin
      @(negedge clk);
      aw_ready = 1'b0; w_ready = 1'b0;
      b_valid = (t == b_dly);
      b_resp  = (t == b_dly) ? resp : 2'($urandom);
      #1;
      chk1("wr_b_ready", b_ready, 1'b1);
      chk1("wr_aw_done", aw_valid, 1'b0);
      chk1("wr_w_done", w_valid, 1'b0);
      chk1("wr_no_pulse", r_valid, 1'b0);
    end
    f = exp_flags(resp);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk1("wr_pulse", r_valid, 1'b1);
    chk1("wr_err", r_err, f[1]);
    chk1("wr_other_err", r_other_err, f[0]);
    chkv("wr_rdata_keep", r_rdata, exp_rdata);
    chk1("wr_b_ready_off", b_ready, 1'b0);
    @(negedge clk);
    #1;
    chk1("wr_pulse_end", r_valid, 1'b0);
  endtask

  initial begin
    logic [1:0] rs;
    rst_n = 1'b0; dmactive = 1'b1; req = 1'b0; add = '0; we = 1'b0; wdata = '0; be = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0; ar_ready = 1'b0;
    s_r_valid = 1'b0; s_r_data = '0; s_r_resp = '0;
    exp_rdata = '0;

    @(negedge clk);
    #1;
    chk_idle_outputs("rst");
    chk1("rst_gnt", gnt, 1'b0);
    chkv("rst_rdata", r_rdata, 32'h0);
    chkv("rst_aw_addr", aw_addr, 32'h0);
    chkv("rst_w_data", w_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_read(32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_write(32'h0000_2000, 32'h1234_5678, 4'b0011, 2'b00, 3, 0, 0);
    do_read(32'h0000_3000, 32'hCAFE_F00D, 2'b11, 1, 2, 1'b0, 1'b0, 1'b0);
    do_write(32'h0000_2004, 32'hA5A5_5A5A, 4'b1100, 2'b10, 0, 2, 1);
    do_read(32'h0000_3004, 32'h0BAD_CAFE, 2'b01, 0, 1, 1'b0, 1'b0, 1'b0);
    do_write(32'h0000_2008, 32'h0F0F_F0F0, 4'b1111, 2'b00, 0, 0, 0);

    // Back-to-back with req held: second grant lands in the first pulse cycle.
    do_read(32'h0000_4000, 32'h1111_2222, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    do_read(32'h0000_4000, 32'h3333_4444, 2'b00, 1, 0, 1'b0, 1'b1, 1'b0);

    // dmactive dropped in WaitR: read drains, then no grants.
    do_read(32'h0000_5000, 32'h5555_6666, 2'b00, 0, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b0; add = 32'h0000_5004;
      #1;
      chk1("dm_off_gnt", gnt, 1'b0);
      chk1("dm_off_ar_valid", ar_valid, 1'b0);
    end
    @(negedge clk);
    req = 1'b0; dmactive = 1'b1;

    // Reset asserted while waiting for B.
    @(negedge clk);
    req = 1'b1; we = 1'b1; add = 32'h0000_6000; wdata = 32'h7777_8888; be = 4'hF;
    #1;
    chk1("rst_wr_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
    #1;
    chk1("rst_wr_aw_valid", aw_valid, 1'b1);
    @(negedge clk);
    aw_ready = 1'b0; w_ready = 1'b0;
    #1;
    chk1("rst_wr_b_ready", b_ready, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk1("async_rst_gnt", gnt, 1'b0);
    chkv("async_rst_aw_addr", aw_addr, 32'h0);
    chkv("async_rst_w_strb", 32'(w_strb), 32'h0);
    chkv("async_rst_rdata", r_rdata, 32'h0);
    exp_rdata = '0;
    @(negedge clk);
    b_valid = 1'b1; b_resp = 2'b00;
    #1;
    chk1("in_rst_b_ready", b_ready, 1'b0);
    @(negedge clk);
    b_valid = 1'b0; rst_n = 1'b1;
    #1;
    chk1("post_rst_r_valid", r_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1("post_rst_r_valid2", r_valid, 1'b0);
    do_read(32'h0000_7000, 32'h89AB_CDEF, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rs = 2'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, $urandom, 4'($urandom), rs,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read($urandom, $urandom, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
